step_pulse_monitor: RTL and testbench
=====================================

Name: step_pulse_monitor

Overview:
- Observes the step/dir/zero-detect signals of one stepper channel, i.e. the drive and dir outputs of a step-motor channel plus that motor's zero-position detector.
- Reconstructs absolute position, measures the step-to-step period and flags motion and limit conditions.
- Used for closed-loop checking of commanded moves and as a position readback register source for software.
- One instance per motor channel.

Parameters:
- C_STEP_NUMBER_WIDTH, 16, width of position, stroke and step counters.
- C_PERIOD_WIDTH, 16, width of period measurement counter.
- C_SYNC_STAGES, 2, synchronizer flops on each asynchronous input (minimum 2).
- C_MIN_LEVEL, 2, consecutive identical synchronized samples of drive required to accept a level change (glitch filter, minimum 1).
- C_IDLE_TIMEOUT, 65535, cycles without an accepted step after which motion is declared stopped (must be ≤ 2^C_PERIOD_WIDTH-1).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- i_drive  input  1  step pulse from motor driver path (asynchronous).
- i_dir  input  1  direction; 1 = toward stroke end (increment), 0 = toward zero (asynchronous).
- i_zpd  input  1  zero-position detector (asynchronous, active high).
- i_clr  input  1  synchronous clear of position, counters and error flags.
- i_stroke  input  C_STEP_NUMBER_WIDTH  terminal position in steps.
- o_position  output  C_STEP_NUMBER_WIDTH  reconstructed absolute position.
- o_step_cnt  output  C_STEP_NUMBER_WIDTH  accepted steps since last clear/idle entry, wraps.
- o_period  output  C_PERIOD_WIDTH  cycles between the last two accepted steps.
- o_period_valid  output  1  one-cycle pulse when o_period updates.
- o_moving  output  1  motion in progress.
- o_dir  output  1  filtered direction latched at last accepted step.
- o_zpsign  output  1  position at zero.
- o_tpsign  output  1  position at stroke.
- o_err_dir  output  1  sticky: dir changed while filtered drive high.
- o_err_ovr  output  1  sticky: step accepted past a limit.

Behaviour:
- Reset (and i_clr): every output 0; internal state IDLE; period counter 0; filter state low. o_zpsign = 1 after reset, since position 0.
- Synchronization: i_drive, i_dir and i_zpd each pass through C_SYNC_STAGES flops.
- Glitch filter: filtered drive (fdrv) changes only after C_MIN_LEVEL consecutive synchronized samples differ from the current fdrv.
- Step event: fdrv 0→1 transition.
- Latency: the first clk edge sampling i_drive=1 is cycle N. The step event is internal at cycle N+C_SYNC_STAGES+C_MIN_LEVEL-1. Registered outputs reflect it one cycle later; with defaults, outputs update at N+4.
- Position on a step event:
  - dir=1 and position<i_stroke: increment.
  - dir=1 and position≥i_stroke: hold, set o_err_ovr.
  - dir=0 and position>0: decrement.
  - dir=0 and position=0: hold, set o_err_ovr.
  - No wrap-around.
- Zero detect: synchronized zpd=1 forces position to 0 every cycle, regardless of any step event. A step event in the same cycle is still counted in o_step_cnt and in period measurement, but not in position.
- Flags: o_zpsign = (position==0); o_tpsign = (position≥i_stroke). Both are combinational compares on the registered position.
- Period counter: cleared to 0 on a step event, otherwise increments, saturating at 2^C_PERIOD_WIDTH-1.
- State machine:
  - IDLE: on step event → FIRST; o_moving←1; o_step_cnt←1. No period output.
  - FIRST: on step event → RUN; o_period←counter+1; o_period_valid pulses.
  - RUN: on each step event, o_period←counter+1 and o_period_valid pulses. Saturated period reports all-ones.
  - FIRST or RUN: when counter reaches C_IDLE_TIMEOUT without a step event → IDLE; o_moving←0.
  - Entering IDLE does not clear o_position or o_period; the next IDLE→FIRST transition reloads o_step_cnt to 1.
- o_dir: latched with the filtered dir at each step event.
- Direction error: filtered dir changes while fdrv=1 → o_err_dir set, sticky until i_clr or reset.
- Priority: reset > i_clr > zpd > step event. A step event coincident with i_clr is discarded.
- Reset mid-pulse: the filter restarts low. A drive still high after reset is accepted as one step after C_MIN_LEVEL samples.

Test Plan:
- Forward run, defaults. i_stroke=100; 10 drive pulses, 4 cycles high and 20 low, dir=1 → o_position=10, o_step_cnt=10, o_period_valid pulses 9 times with o_period=24, o_moving=1. o_moving drops 65535 cycles after the last step.
- Glitch rejection. 1-cycle drive highs, 50 of them → position unchanged at 0, no period pulse. 2-cycle high → exactly one step, with outputs updating 4 cycles after first sampled high.
- Limits. Position 0, dir=0, 3 pulses → position 0, o_err_ovr=1, o_zpsign=1. i_stroke=5, 7 forward pulses → position 5, o_tpsign=1, o_err_ovr=1.
- Zero detect override. Position 40; assert i_zpd during a forward pulse → position 0 while zpd high, o_step_cnt increments. After zpd falls, the next forward pulse gives position 1.
- Direction error and clear. Toggle i_dir while drive held high 6 cycles → o_err_dir=1. Pulse i_clr coincident with a step event → all outputs 0, the step is not counted, state IDLE.
- Period saturation. C_PERIOD_WIDTH=8, C_IDLE_TIMEOUT=255; two steps 300 cycles apart → second step enters FIRST, since the machine idled at 255. A third step 100 cycles later → o_period=100.

Source files
------------

// File: rtl/step_pulse_monitor.sv
// step_pulse_monitor: watches one stepper channel's drive/dir/zero-detect
// lines and rebuilds absolute position, step period and motion/limit flags.
module step_pulse_monitor #(
  parameter int C_STEP_NUMBER_WIDTH = 16,
  parameter int C_PERIOD_WIDTH      = 16,
  parameter int C_SYNC_STAGES       = 2,
  parameter int C_MIN_LEVEL         = 2,
  parameter int C_IDLE_TIMEOUT      = 65535
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           i_drive,
  input  logic                           i_dir,
  input  logic                           i_zpd,
  input  logic                           i_clr,
  input  logic [C_STEP_NUMBER_WIDTH-1:0] i_stroke,
  output logic [C_STEP_NUMBER_WIDTH-1:0] o_position,
  output logic [C_STEP_NUMBER_WIDTH-1:0] o_step_cnt,
  output logic [C_PERIOD_WIDTH-1:0]      o_period,
  output logic                           o_period_valid,
  output logic                           o_moving,
  output logic                           o_dir,
  output logic                           o_zpsign,
  output logic                           o_tpsign,
  output logic                           o_err_dir,
  output logic                           o_err_ovr
);

  localparam int SW = C_STEP_NUMBER_WIDTH;
  localparam int PW = C_PERIOD_WIDTH;
  localparam int FW = $clog2(C_MIN_LEVEL + 1);
  localparam logic [FW-1:0] FLT_LAST = FW'(C_MIN_LEVEL - 1);
  localparam logic [PW-1:0] PER_MAX  = '1;
  localparam logic [PW-1:0] IDLE_TO  = PW'(C_IDLE_TIMEOUT);

  typedef enum logic [1:0] {IDLE, FIRST, RUN} state_t;

  logic [C_SYNC_STAGES-1:0] drv_sync_q, dir_sync_q, zpd_sync_q;
  logic                     drv_s, dir_s, zpd_s;
  logic                     fdrv_q, fdrv_prev_q, dir_prev_q;
  logic [FW-1:0]            flt_cnt_q;
  logic [PW-1:0]            per_cnt_q, per_next;
  logic                     step;
  state_t                   state_q, state_d;
  logic                     per_load, cnt_start, cnt_inc, move_set, move_clr;
  logic [SW-1:0]            pos_q, step_cnt_q;
  logic [PW-1:0]            period_q;
  logic                     period_valid_q, moving_q, dir_q, err_dir_q, err_ovr_q;

  assign drv_s = drv_sync_q[C_SYNC_STAGES-1];
  assign dir_s = dir_sync_q[C_SYNC_STAGES-1];
  assign zpd_s = zpd_sync_q[C_SYNC_STAGES-1];

  // Metastability synchronizers for the three asynchronous inputs
  always_ff @(posedge clk) begin
    if (reset) begin
      drv_sync_q <= '0;
      dir_sync_q <= '0;
      zpd_sync_q <= '0;
    end else begin
      drv_sync_q <= {drv_sync_q[C_SYNC_STAGES-2:0], i_drive};
      dir_sync_q <= {dir_sync_q[C_SYNC_STAGES-2:0], i_dir};
      zpd_sync_q <= {zpd_sync_q[C_SYNC_STAGES-2:0], i_zpd};
    end
  end

  // Glitch filter: fdrv flips only after C_MIN_LEVEL consecutive differing samples
  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      fdrv_q      <= 1'b0;
      fdrv_prev_q <= 1'b0;
      flt_cnt_q   <= '0;
      dir_prev_q  <= 1'b0;
    end else begin
      fdrv_prev_q <= fdrv_q;
      dir_prev_q  <= dir_s;
      if (drv_s != fdrv_q) begin
        if (flt_cnt_q == FLT_LAST) begin
          fdrv_q    <= drv_s;
          flt_cnt_q <= '0;
        end else begin
          flt_cnt_q <= flt_cnt_q + 1'b1;
        end
      end else begin
        flt_cnt_q <= '0;
      end
    end
  end

  // A step is a rising edge of the filtered drive; a coincident clear discards it
  assign step     = fdrv_q & ~fdrv_prev_q & ~i_clr;
  assign per_next = (per_cnt_q == PER_MAX) ? PER_MAX : per_cnt_q + 1'b1;

  // Saturating cycle counter measuring the gap since the last step
  always_ff @(posedge clk) begin
    if (reset || i_clr) per_cnt_q <= '0;
    else if (step)      per_cnt_q <= '0;
    else                per_cnt_q <= per_next;
  end

  // Motion state register
  always_ff @(posedge clk) begin
    if (reset || i_clr) state_q <= IDLE;
    else                state_q <= state_d;
  end

  // Motion next-state and per-transition controls
  always_comb begin
    state_d   = state_q;
    per_load  = 1'b0;
    cnt_start = 1'b0;
    cnt_inc   = 1'b0;
    move_set  = 1'b0;
    move_clr  = 1'b0;
    case (state_q)
      IDLE: begin
        if (step) begin
          state_d   = FIRST;
          cnt_start = 1'b1;
          move_set  = 1'b1;
        end
      end
      FIRST, RUN: begin
        if (step) begin
          state_d  = RUN;
          per_load = 1'b1;
          cnt_inc  = 1'b1;
        end else if (per_cnt_q >= IDLE_TO) begin
          state_d  = IDLE;
          move_clr = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Position, counters, period report and sticky error flags
  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      pos_q          <= '0;
      step_cnt_q     <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      moving_q       <= 1'b0;
      dir_q          <= 1'b0;
      err_dir_q      <= 1'b0;
      err_ovr_q      <= 1'b0;
    end else begin
      period_valid_q <= per_load;
      if (per_load)  period_q   <= per_next;
      if (cnt_start) step_cnt_q <= SW'(1);
      else if (cnt_inc) step_cnt_q <= step_cnt_q + 1'b1;
      if (move_set)      moving_q <= 1'b1;
      else if (move_clr) moving_q <= 1'b0;
      if (step) dir_q <= dir_s;
      if (fdrv_q && (dir_s != dir_prev_q)) err_dir_q <= 1'b1;
      // Zero detector wins over any step; limits hold position and flag overrun
      if (zpd_s) begin
        pos_q <= '0;
      end else if (step) begin
        if (dir_s) begin
          if (pos_q < i_stroke) pos_q <= pos_q + 1'b1;
          else                  err_ovr_q <= 1'b1;
        end else begin
          if (pos_q != '0) pos_q <= pos_q - 1'b1;
          else             err_ovr_q <= 1'b1;
        end
      end
    end
  end

  assign o_position     = pos_q;
  assign o_step_cnt     = step_cnt_q;
  assign o_period       = period_q;
  assign o_period_valid = period_valid_q;
  assign o_moving       = moving_q;
  assign o_dir          = dir_q;
  assign o_err_dir      = err_dir_q;
  assign o_err_ovr      = err_ovr_q;
  assign o_zpsign       = (pos_q == '0);
  assign o_tpsign       = (pos_q >= i_stroke);

endmodule

// File: tb/tb_step_pulse_monitor.sv
// Directed bench for step_pulse_monitor (short period/timeout build).
module tb_step_pulse_monitor;
  logic        clk = 1'b0;
  logic        reset, i_drive, i_dir, i_zpd, i_clr;
  logic [15:0] i_stroke;
  logic [15:0] o_position, o_step_cnt;
  logic [7:0]  o_period;
  logic        o_period_valid, o_moving, o_dir, o_zpsign, o_tpsign, o_err_dir, o_err_ovr;

  int errors = 0;
  int checks = 0;
  int pv_cnt = 0;
  int pv_base;

  step_pulse_monitor #(
    .C_STEP_NUMBER_WIDTH(16), .C_PERIOD_WIDTH(8), .C_SYNC_STAGES(2),
    .C_MIN_LEVEL(2), .C_IDLE_TIMEOUT(255)
  ) dut (
    .clk(clk), .reset(reset), .i_drive(i_drive), .i_dir(i_dir), .i_zpd(i_zpd),
    .i_clr(i_clr), .i_stroke(i_stroke), .o_position(o_position),
    .o_step_cnt(o_step_cnt), .o_period(o_period), .o_period_valid(o_period_valid),
    .o_moving(o_moving), .o_dir(o_dir), .o_zpsign(o_zpsign), .o_tpsign(o_tpsign),
    .o_err_dir(o_err_dir), .o_err_ovr(o_err_ovr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (o_period_valid) pv_cnt++;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input int hi, input int lo);
    i_drive = 1'b1;
    tick(hi);
    i_drive = 1'b0;
    tick(lo);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_pulse();
    i_clr = 1'b1;
    tick(1);
    i_clr = 1'b0;
    tick(1);
  endtask

  initial begin
    reset = 1'b1; i_drive = 1'b0; i_dir = 1'b0; i_zpd = 1'b0; i_clr = 1'b0;
    i_stroke = 16'd100;
    tick(3);
    reset = 1'b0;
    tick(1);
    chk("rst_pos", o_position, 0);
    chk("rst_cnt", o_step_cnt, 0);
    chk("rst_period", o_period, 0);
    chk("rst_moving", o_moving, 0);
    chk("rst_zpsign", o_zpsign, 1);
    chk("rst_tpsign", o_tpsign, 0);
    chk("rst_errs", {o_err_dir, o_err_ovr, o_dir, o_period_valid}, 0);

    // Forward run: 10 pulses, period 24
    i_dir = 1'b1;
    tick(4);
    pv_base = pv_cnt;
    repeat (10) pulse(4, 20);
    chk("fwd_pos", o_position, 10);
    chk("fwd_cnt", o_step_cnt, 10);
    chk("fwd_pv_count", pv_cnt - pv_base, 9);
    chk("fwd_period", o_period, 24);
    chk("fwd_moving", o_moving, 1);
    chk("fwd_dir", o_dir, 1);
    tick(200);
    chk("idle_not_yet", o_moving, 1);
    tick(60);
    chk("idle_moving", o_moving, 0);
    chk("idle_pos_kept", o_position, 10);
    chk("idle_period_kept", o_period, 24);

    // Glitch rejection: single-cycle highs are ignored
    pv_base = pv_cnt;
    repeat (50) pulse(1, 3);
    tick(6);
    chk("glitch_pos", o_position, 10);
    chk("glitch_cnt", o_step_cnt, 10);
    chk("glitch_pv", pv_cnt - pv_base, 0);
    chk("glitch_moving", o_moving, 0);
    // Two-cycle high is one step, visible 4 edges after the first sampling edge
    i_drive = 1'b1;
    tick(2);
    i_drive = 1'b0;
    tick(2);
    chk("lat_before", o_position, 10);
    tick(1);
    chk("lat_pos", o_position, 11);
    chk("lat_cnt", o_step_cnt, 1);
    chk("lat_moving", o_moving, 1);
    tick(300);

    // Lower limit
    clear_pulse();
    chk("clr_pos", o_position, 0);
    i_dir = 1'b0;
    tick(4);
    repeat (3) pulse(4, 20);
    chk("low_pos", o_position, 0);
    chk("low_ovr", o_err_ovr, 1);
    chk("low_zpsign", o_zpsign, 1);
    chk("low_cnt", o_step_cnt, 3);
    // Upper limit
    clear_pulse();
    i_stroke = 16'd5;
    i_dir = 1'b1;
    tick(4);
    repeat (7) pulse(4, 20);
    chk("hi_pos", o_position, 5);
    chk("hi_tpsign", o_tpsign, 1);
    chk("hi_zpsign", o_zpsign, 0);
    chk("hi_ovr", o_err_ovr, 1);
    chk("hi_cnt", o_step_cnt, 7);
    chk("hi_errdir", o_err_dir, 0);

    // Zero detect override
    clear_pulse();
    i_stroke = 16'd100;
    repeat (40) pulse(4, 4);
    tick(4);
    chk("zpd_pre_pos", o_position, 40);
    chk("zpd_pre_cnt", o_step_cnt, 40);
    i_zpd = 1'b1;
    tick(4);
    chk("zpd_force", o_position, 0);
    pulse(4, 20);
    chk("zpd_step_pos", o_position, 0);
    chk("zpd_step_cnt", o_step_cnt, 41);
    i_zpd = 1'b0;
    tick(4);
    chk("zpd_released", o_position, 0);
    pulse(4, 20);
    chk("zpd_after_pos", o_position, 1);
    chk("zpd_after_cnt", o_step_cnt, 42);

    // Direction error: dir toggles while drive held high
    clear_pulse();
    i_drive = 1'b1;
    tick(3);
    i_dir = 1'b0;
    tick(3);
    i_drive = 1'b0;
    tick(20);
    chk("derr_flag", o_err_dir, 1);
    chk("derr_pos", o_position, 1);
    chk("derr_dir", o_dir, 1);
    // Clear coincident with the internal step event
    i_drive = 1'b1;
    tick(4);
    i_drive = 1'b0;
    i_clr = 1'b1;
    tick(1);
    i_clr = 1'b0;
    chk("clr_all", {o_position, o_step_cnt, 8'(o_period)}, 0);
    chk("clr_flags", {o_moving, o_dir, o_err_dir, o_err_ovr, o_period_valid}, 0);
    tick(10);
    chk("clr_step_dropped", o_step_cnt, 0);
    chk("clr_zpsign", o_zpsign, 1);
    i_dir = 1'b1;
    tick(4);
    pv_base = pv_cnt;
    pulse(4, 20);
    chk("clr_idle_cnt", o_step_cnt, 1);
    chk("clr_idle_pv", pv_cnt - pv_base, 0);
    chk("clr_idle_pos", o_position, 1);
    tick(300);

    // Idle timeout before second step, then a 100-cycle period
    clear_pulse();
    pv_base = pv_cnt;
    pulse(4, 296);
    chk("sat_first_cnt", o_step_cnt, 1);
    chk("sat_idled", o_moving, 0);
    pulse(4, 96);
    chk("sat_second_cnt", o_step_cnt, 1);
    chk("sat_second_pv", pv_cnt - pv_base, 0);
    chk("sat_second_moving", o_moving, 1);
    pulse(4, 20);
    chk("sat_period", o_period, 100);
    chk("sat_third_cnt", o_step_cnt, 2);
    chk("sat_third_pv", pv_cnt - pv_base, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
